// File: rtl/instr_loader_pkg.sv
// Shared definitions for the serial instruction loader: FSM encoding,
// supported opcodes and the per-state registered control outputs.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    CHECK,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loaderState_t;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_INC    = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ORI    = 6'h0D;

  typedef struct packed {
    logic byteReady;
    logic memWe;
    logic busy;
    logic cpuHold;
    logic done;
  } loaderCtrl_t;

  // Control outputs are loaded together with the state they belong to,
  // so every output is a flop and matches the state it is paired with.
  function automatic loaderCtrl_t ctrlFor(input loaderState_t s);
    loaderCtrl_t c;
    c           = '0;
    c.byteReady = (s inside {LEN_HI, LEN_LO, DATA});
    c.memWe     = (s == WRITE);
    c.busy      = !(s inside {IDLE, ERROR});
    c.cpuHold   = (s != IDLE);
    c.done      = (s == DONE);
    return c;
  endfunction

endpackage

// File: rtl/instr_loader_opcode_check.sv
// Combinational legality check of a 6-bit instruction opcode against the
// set of opcodes the target processor implements.
module opcode_check (
  input  logic [5:0] opcode,
  output logic       legal
);
  import instr_loader_pkg::*;

  assign legal = opcode inside {OP_R_TYPE, OP_INC, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI};

endmodule

// File: rtl/instr_loader.sv
// Receives a length-prefixed big-endian byte stream, writes it word by word
// into instruction memory and holds the CPU in reset until the load completes.
module instr_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            illegal_count
);
  import instr_loader_pkg::*;

  // Length field is 16 bits, so the memory depth is compared in 17 bits.
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  loaderState_t          state;
  loaderCtrl_t           ctrl;
  logic [15:0]           lenCount;
  logic [ADDR_WIDTH:0]   wordCount;
  logic [ADDR_WIDTH:0]   wordNext;
  logic [1:0]            byteIdx;
  logic [23:0]           shiftReg;
  logic                  accept;
  logic                  opLegal;

  assign accept   = byte_valid & ctrl.byteReady;
  assign wordNext = wordCount + (ADDR_WIDTH+1)'(1);

  opcode_check u_opcode_check (
    .opcode (mem_wdata[31:26]),
    .legal  (opLegal)
  );

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch reads the values from before this edge, independent of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ctrl          <= ctrlFor(IDLE);
      lenCount      <= '0;
      wordCount     <= '0;
      byteIdx       <= '0;
      shiftReg      <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      error         <= 1'b0;
      illegal_count <= '0;
    end else begin
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            state         <= LEN_HI;
            ctrl          <= ctrlFor(LEN_HI);
            error         <= 1'b0;
            illegal_count <= '0;
            wordCount     <= '0;
            byteIdx       <= '0;
          end
        end

        LEN_HI: begin
          if (accept) begin
            lenCount[15:8] <= byte_in;
            state          <= LEN_LO;
            ctrl           <= ctrlFor(LEN_LO);
          end
        end

        LEN_LO: begin
          if (accept) begin
            lenCount[7:0] <= byte_in;
            state         <= CHECK;
            ctrl          <= ctrlFor(CHECK);
          end
        end

        CHECK: begin
          if (lenCount == 16'd0) begin
            state <= DONE;
            ctrl  <= ctrlFor(DONE);
          end else if ({1'b0, lenCount} > DEPTH) begin
            state <= ERROR;
            ctrl  <= ctrlFor(ERROR);
            error <= 1'b1;
          end else begin
            state <= DATA;
            ctrl  <= ctrlFor(DATA);
          end
        end

        DATA: begin
          if (accept) begin
            shiftReg <= {shiftReg[15:0], byte_in};
            byteIdx  <= byteIdx + 2'd1;
            if (byteIdx == 2'd3) begin
              mem_wdata <= {shiftReg, byte_in};
              mem_addr  <= wordCount[ADDR_WIDTH-1:0];
              state     <= WRITE;
              ctrl      <= ctrlFor(WRITE);
            end
          end
        end

        WRITE: begin
          wordCount <= wordNext;
          if (!opLegal && illegal_count != 8'hFF)
            illegal_count <= illegal_count + 8'd1;
          // wordNext carries one extra bit so a full-depth load still matches.
          if (17'(wordNext) == {1'b0, lenCount}) begin
            state <= DONE;
            ctrl  <= ctrlFor(DONE);
          end else begin
            state <= DATA;
            ctrl  <= ctrlFor(DATA);
          end
        end

        DONE: begin
          state <= IDLE;
          ctrl  <= ctrlFor(IDLE);
        end

        default: begin
          state <= IDLE;
          ctrl  <= ctrlFor(IDLE);
        end
      endcase
    end
  end

  assign byte_ready = ctrl.byteReady;
  assign mem_we     = ctrl.memWe;
  assign busy       = ctrl.busy;
  assign cpu_hold   = ctrl.cpuHold;
  assign done       = ctrl.done;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: normal loads, illegal opcodes, length
// errors, zero length, a full-depth load with stalls and mid-load reset.
module tb_instr_loader;

  localparam int ADDR_WIDTH = 8;
  localparam int LOG_DEPTH  = 1024;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [7:0]            byte_in = 8'h00;
  logic                  byte_valid = 1'b0;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_hold;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [7:0]            illegal_count;

  int nChecks = 0;
  int nFail   = 0;

  int writeCount = 0;
  int doneCount  = 0;
  logic [31:0] logAddr [LOG_DEPTH];
  logic [31:0] logData [LOG_DEPTH];

  instr_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write/done monitor, sampled on the falling edge while outputs are stable.
  always @(negedge clk) begin
    if (mem_we) begin
      if (writeCount < LOG_DEPTH) begin
        logAddr[writeCount] <= 32'(mem_addr);
        logData[writeCount] <= mem_wdata;
      end
      writeCount <= writeCount + 1;
      check("ready_in_write", 32'(byte_ready), 32'd0);
    end
    if (done) doneCount <= doneCount + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int maxGap);
    int n;
    if (maxGap > 0) begin
      repeat ($urandom_range(0, maxGap)) begin
        byte_valid = 1'b0;
        step();
      end
    end
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 20) begin
      step();
      n++;
    end
    if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    logic [31:0] v;
    v = w;
    sendByte(v[31:24], maxGap);
    sendByte(v[23:16], maxGap);
    sendByte(v[15:8],  maxGap);
    sendByte(v[7:0],   maxGap);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int wBase;
    int dBase;
    logic [31:0] w;

    // Reset state
    step();
    step();
    reset = 1'b0;
    check("rst_ready",   32'(byte_ready),    32'd0);
    check("rst_we",      32'(mem_we),        32'd0);
    check("rst_addr",    32'(mem_addr),      32'd0);
    check("rst_wdata",   mem_wdata,          32'd0);
    check("rst_hold",    32'(cpu_hold),      32'd0);
    check("rst_busy",    32'(busy),          32'd0);
    check("rst_done",    32'(done),          32'd0);
    check("rst_error",   32'(error),         32'd0);
    check("rst_illegal", 32'(illegal_count), 32'd0);

    // Two-word program, back-to-back bytes
    wBase = writeCount;
    dBase = doneCount;
    doStart();
    check("p2_ready", 32'(byte_ready), 32'd1);
    check("p2_busy",  32'(busy),       32'd1);
    check("p2_hold",  32'(cpu_hold),   32'd1);
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    sendWord(32'h2008_0005, 0);
    sendWord(32'h3409_000F, 0);
    waitDone("p2_done", 20);
    check("p2_hold_at_done", 32'(cpu_hold), 32'd1);
    step();
    check("p2_hold_after", 32'(cpu_hold), 32'd0);
    check("p2_busy_after", 32'(busy),     32'd0);
    check("p2_done_after", 32'(done),     32'd0);
    check("p2_writes",     32'(writeCount - wBase), 32'd2);
    check("p2_done_count", 32'(doneCount - dBase),  32'd1);
    check("p2_addr0", logAddr[wBase],     32'd0);
    check("p2_data0", logData[wBase],     32'h2008_0005);
    check("p2_addr1", logAddr[wBase + 1], 32'd1);
    check("p2_data1", logData[wBase + 1], 32'h3409_000F);
    check("p2_illegal", 32'(illegal_count), 32'd0);

    // One word with an unsupported opcode
    wBase = writeCount;
    doStart();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendWord(32'hFC00_0000, 0);
    waitDone("p1_done", 20);
    step();
    check("p1_writes",  32'(writeCount - wBase), 32'd1);
    check("p1_data",    logData[wBase],          32'hFC00_0000);
    check("p1_illegal", 32'(illegal_count),      32'd1);

    // Length 257 overflows a 256-word memory
    wBase = writeCount;
    doStart();
    check("len_illegal_cleared", 32'(illegal_count), 32'd0);
    sendByte(8'h01, 0);
    sendByte(8'h01, 0);
    step();
    check("len_error", 32'(error),      32'd1);
    check("len_hold",  32'(cpu_hold),   32'd1);
    check("len_busy",  32'(busy),       32'd0);
    check("len_ready", 32'(byte_ready), 32'd0);
    step();
    step();
    check("len_error_held", 32'(error), 32'd1);
    check("len_no_write", 32'(writeCount - wBase), 32'd0);

    // Restart from ERROR with a zero-length program
    dBase = doneCount;
    doStart();
    check("z_error_cleared", 32'(error), 32'd0);
    check("z_busy",          32'(busy),  32'd1);
    sendByte(8'h00, 0);
    sendByte(8'h00, 0);
    check("z_ready_after_len", 32'(byte_ready), 32'd0);
    waitDone("z_done", 5);
    step();
    check("z_no_write",   32'(writeCount - wBase), 32'd0);
    check("z_done_count", 32'(doneCount - dBase),  32'd1);

    // Full-depth load with random stalls; every opcode illegal so the
    // counter must saturate at 255 rather than wrap.
    wBase = writeCount;
    dBase = doneCount;
    doStart();
    sendByte(8'h01, 2);
    sendByte(8'h00, 2);
    for (int i = 0; i < 256; i++) begin
      w = 32'hFC00_0000 | (32'(i) << 8) | (32'(i) ^ 32'hFF);
      sendWord(w, 2);
    end
    waitDone("full_done", 20);
    step();
    check("full_writes",     32'(writeCount - wBase), 32'd256);
    check("full_done_count", 32'(doneCount - dBase),  32'd1);
    check("full_error",      32'(error),              32'd0);
    check("full_illegal",    32'(illegal_count),      32'd255);
    for (int i = 0; i < 256; i++) begin
      w = 32'hFC00_0000 | (32'(i) << 8) | (32'(i) ^ 32'hFF);
      check("full_addr", logAddr[wBase + i], 32'(i));
      check("full_data", logData[wBase + i], w);
    end

    // Reset in the middle of a word abandons the load
    wBase = writeCount;
    doStart();
    sendByte(8'h00, 0);
    sendByte(8'h02, 0);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    reset = 1'b1;
    step();
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_we",    32'(mem_we),     32'd0);
    check("mid_rst_hold",  32'(cpu_hold),   32'd0);
    check("mid_rst_busy",  32'(busy),       32'd0);
    check("mid_rst_error", 32'(error),      32'd0);
    check("mid_rst_addr",  32'(mem_addr),   32'd0);
    check("mid_rst_wdata", mem_wdata,       32'd0);

    // Reset wins over a simultaneous start
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    step();
    check("mid_no_write", 32'(writeCount - wBase), 32'd0);

    // Reload after the abort starts again at address 0
    wBase = writeCount;
    doStart();
    sendByte(8'h00, 0);
    sendByte(8'h01, 0);
    sendWord(32'h0400_0001, 0);
    waitDone("reload_done", 20);
    step();
    check("reload_writes", 32'(writeCount - wBase), 32'd1);
    check("reload_addr",   logAddr[wBase],          32'd0);
    check("reload_data",   logData[wBase],          32'h0400_0001);
    check("reload_illegal", 32'(illegal_count),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: ADDR_WIDTH, default 8, instruction memory word-address width (depth 2^ADDR_WIDTH words).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a program load.
REQ-005 byte_in  input  8  serial program stream byte.
REQ-006 byte_valid  input  1  byte_in holds a valid byte.
REQ-007 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-008 mem_we  output  1  instruction memory write strobe.
REQ-009 mem_addr  output  ADDR_WIDTH  instruction memory word address.
REQ-010 mem_wdata  output  32  instruction word to write.
REQ-011 cpu_hold  output  1  holds the processor in reset while the program is incomplete.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  one-cycle pulse on successful load completion.
REQ-014 error  output  1  length error, held until the next start or reset.
REQ-015 illegal_count  output  8  saturating count of loaded words with an unsupported opcode.

Function
REQ-016 A byte is accepted only on a cycle where byte_valid and byte_ready are both 1.
REQ-017 FSM states: IDLE, LEN_HI, LEN_LO, CHECK, DATA, WRITE, DONE, ERROR.
REQ-018 IDLE or ERROR with start=1 -> LEN_HI; clears error, illegal_count, word counter and byte index; start is ignored in all other states.
REQ-019 LEN_HI and LEN_LO each accept one byte forming 16-bit word count N, big-endian.
REQ-020 CHECK lasts one cycle: N=0 -> DONE; N>2^ADDR_WIDTH -> ERROR; otherwise -> DATA.
REQ-021 DATA accepts 4 bytes, big-endian (first byte = bits 31:24); after the 4th accepted byte the next state is WRITE.
REQ-022 WRITE lasts exactly one cycle: mem_we=1, mem_addr = word counter (starting at 0), mem_wdata = assembled word; the word counter then increments.
REQ-023 After WRITE: if words written == N -> DONE, else -> DATA.
REQ-024 byte_ready is 1 only in LEN_HI, LEN_LO and DATA; it is 0 in all other states, including WRITE.
REQ-025 mem_we is 1 only in WRITE; mem_addr and mem_wdata are don't-care otherwise but must not glitch mem_we.
REQ-026 On each WRITE, if instruction bits 31:26 are not in {0x00, 0x01, 0x04, 0x05, 0x08, 0x0D}, illegal_count increments, saturating at 255; the word is still written.
REQ-027 DONE lasts one cycle: done=1, then -> IDLE.
REQ-028 busy = 1 in every state except IDLE and ERROR.
REQ-029 cpu_hold = 1 from the cycle after start is accepted through the DONE cycle inclusive, and throughout ERROR; it is 0 in IDLE.
REQ-030 Stalls are unbounded: the FSM waits indefinitely in LEN_HI, LEN_LO or DATA for byte_valid.
REQ-031 N = 2^ADDR_WIDTH is legal; the last write goes to address 2^ADDR_WIDTH-1 and the counter must not wrap before the DONE comparison (counter is ADDR_WIDTH+1 bits).

Reset
REQ-032 With reset=1 at a clock edge: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, illegal_count=0, word counter=0, byte index=0.
REQ-033 Reset asserted mid-load aborts immediately; no further memory write occurs, and the partial load is abandoned without error.
REQ-034 Reset takes priority over start and byte acceptance in the same cycle.

Structure
REQ-035 A shared package holds the FSM state encoding and the supported-opcode constants (R_TYPE 0x00, INC 0x01, BEQ 0x04, BNE 0x05, ADDI 0x08, ORI 0x0D), which the control decoder also uses.
REQ-036 A single sub-module, opcode_check (combinational, 6-bit opcode in, legal flag out), is instantiated once.

Verification
REQ-037 Stream 00 02, 20 08 00 05, 34 09 00 0F with byte_valid held 1 -> writes 0x20080005 @0, then 0x3409000F @1; done pulses once; illegal_count=0; cpu_hold falls the cycle after done.
REQ-038 N=1, word FC000000 -> one write; illegal_count=1; done=1.
REQ-039 ADDR_WIDTH=8, length 01 01 (257) -> ERROR after CHECK; error=1; cpu_hold=1; no mem_we; a new start clears error.
REQ-040 Length 00 00 -> done pulse with no mem_we; byte_ready=0 after LEN_LO.
REQ-041 Random byte_valid gaps over a 256-word load -> addresses 0..255 written in order, byte_ready=0 in every WRITE cycle, 256 writes, single done.
REQ-042 Reset asserted after 2 of 4 data bytes -> all outputs at reset values the next cycle; no write; a subsequent start reloads from address 0.
